trigger_window_gen: RTL and testbench

Memory-mapped trigger-window generator for the Ibex demo system. Firmware arms it over the device bus, and it drives the trigger bit of `gpio_o` high for a precise, cycle-counted window. It is the producer side of the trigger that the simulation benches and external glitch/capture equipment watch on the GPIO pins. It also drives the remaining GPIO output bits from a software register.

---
 rtl/trigger_window_gen.sv | 214 +++++++++++++++++++++
 tb/tb_trigger_window_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_window_gen.sv
// trigger_window_gen
//   Memory-mapped trigger-window generator. Firmware arms it over the device
//   bus; it holds gpio_o[TRIGGERBIT] high for a cycle-counted window, either
//   after a programmable delay (ARM_AUTO) or immediately (START_MANUAL). The
//   window closes after LENGTH cycles, or on STOP when LENGTH is 0. The other
//   GPIO bits come from the software GPIO_OUT register.
//
// Ports
//   clk, rst       : single clock, synchronous active-high reset
//   dev_req_i      : single-cycle bus request
//   dev_we_i       : write enable
//   dev_be_i       : byte enables
//   dev_addr_i     : byte address, [4:2] selects the word
//   dev_wdata_i    : write data
//   dev_rvalid_o   : response valid, one cycle after every request
//   dev_rdata_o    : read data (0 when not a read response)
//   gpio_o         : GPIO_OUT with bit TRIGGERBIT replaced by trigger_o
//   trigger_o      : registered trigger level (high while ACTIVE)
//   busy_o         : high while in DELAY or ACTIVE
//
// Register map (word offsets)
//   0x00 CTRL   W   b0 START_MANUAL, b1 ARM_AUTO, b2 STOP, b3 CLEAR (be[0] only)
//   0x04 DELAY  RW  delay before the window (locked while busy)
//   0x08 LENGTH RW  window length, 0 = ends on STOP (locked while busy)
//   0x0C STATUS R   [1:0] state, b2 done
//   0x10 CYCLES R   cycles the trigger was high in the last window
//   0x14 GPIO   RW  GPIO_OUT, byte-enabled
module trigger_window_gen #(
  parameter int GPIO_W     = 8,
  parameter int TRIGGERBIT = 0,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dev_req_i,
  input  logic              dev_we_i,
  input  logic [3:0]        dev_be_i,
  input  logic [4:0]        dev_addr_i,
  input  logic [31:0]       dev_wdata_i,
  output logic              dev_rvalid_o,
  output logic [31:0]       dev_rdata_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              trigger_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [2:0] W_CTRL   = 3'd0;
  localparam logic [2:0] W_DELAY  = 3'd1;
  localparam logic [2:0] W_LENGTH = 3'd2;
  localparam logic [2:0] W_STATUS = 3'd3;
  localparam logic [2:0] W_CYCLES = 3'd4;
  localparam logic [2:0] W_GPIO   = 3'd5;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              done_q, done_d;
  logic              trigger_q;
  logic [CNT_W-1:0]  delay_q, length_q;
  logic [GPIO_W-1:0] gpio_q;
  logic              rvalid_p1;
  logic [31:0]       rdata_p1, rdata_d;

  logic       wr_en, rd_en, cfg_open;
  logic [2:0] word;
  logic       ctrl_wr, c_start, c_arm, c_stop, c_clear;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^dev_addr_i[1:0];

  assign word     = dev_addr_i[4:2];
  assign wr_en    = dev_req_i & dev_we_i;
  assign rd_en    = dev_req_i & ~dev_we_i;
  assign cfg_open = (state_q == ST_IDLE) || (state_q == ST_DONE);

  assign ctrl_wr = wr_en && (word == W_CTRL) && dev_be_i[0];
  assign c_start = ctrl_wr & dev_wdata_i[0];
  assign c_arm   = ctrl_wr & dev_wdata_i[1];
  assign c_stop  = ctrl_wr & dev_wdata_i[2];
  assign c_clear = ctrl_wr & dev_wdata_i[3];

  // In ACTIVE, cnt_q holds the number of completed high cycles, so cnt_inc
  // is the count including the current one.
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    done_d   = done_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (c_arm) begin
          done_d = 1'b0;
          if (delay_q == '0) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_q;
          end
        end else if (c_start) begin
          done_d  = 1'b0;
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else if (c_clear && (state_q == ST_DONE)) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (c_stop) begin
          state_d  = ST_DONE;
          cycles_d = '0;
          done_d   = 1'b1;
        end else if (cnt_q == CNT_W'(1)) begin
          // Last delay cycle: the trigger rises DELAY+1 cycles after arming.
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        // STOP and auto-expiry latch the same count, so no priority is needed.
        if (c_stop || ((length_q != '0) && (cnt_inc == length_q))) begin
          state_d  = ST_DONE;
          cycles_d = cnt_inc;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
      trigger_q <= (state_d == ST_ACTIVE);
    end
  end

  always_comb begin
    rdata_d = '0;
    unique case (word)
      W_DELAY:  rdata_d = 32'(delay_q);
      W_LENGTH: rdata_d = 32'(length_q);
      W_STATUS: rdata_d = {29'd0, done_q, state_q};
      W_CYCLES: rdata_d = 32'(cycles_q);
      W_GPIO:   rdata_d = 32'(gpio_q);
      default:  rdata_d = '0;
    endcase
  end

  // Bus response stage: one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q   <= '0;
      length_q  <= '0;
      gpio_q    <= '0;
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      if (wr_en && (word == W_DELAY) && cfg_open)
        delay_q <= CNT_W'(be_merge(32'(delay_q), dev_wdata_i, dev_be_i));
      if (wr_en && (word == W_LENGTH) && cfg_open)
        length_q <= CNT_W'(be_merge(32'(length_q), dev_wdata_i, dev_be_i));
      if (wr_en && (word == W_GPIO))
        gpio_q <= GPIO_W'(be_merge(32'(gpio_q), dev_wdata_i, dev_be_i));
      rvalid_p1 <= dev_req_i;
      rdata_p1  <= rd_en ? rdata_d : '0;
    end
  end

  always_comb begin
    gpio_o             = gpio_q;
    gpio_o[TRIGGERBIT] = trigger_q;
  end

  assign trigger_o    = trigger_q;
  assign busy_o       = (state_q == ST_DELAY) || (state_q == ST_ACTIVE);
  assign dev_rvalid_o = rvalid_p1;
  assign dev_rdata_o  = rdata_p1;

endmodule

// File: tb/tb_trigger_window_gen.sv
// Testbench for trigger_window_gen: directed scenarios followed by random bus
// traffic, checked against a timestamp-based model of the trigger window.
module tb_trigger_window_gen;

  localparam int GPIO_W     = 8;
  localparam int TRIGGERBIT = 0;
  localparam int CNT_W      = 32;
  localparam longint INF    = 64'h1000_0000_0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              dev_req_i;
  logic              dev_we_i;
  logic [3:0]        dev_be_i;
  logic [4:0]        dev_addr_i;
  logic [31:0]       dev_wdata_i;
  logic              dev_rvalid_o;
  logic [31:0]       dev_rdata_o;
  logic [GPIO_W-1:0] gpio_o;
  logic              trigger_o;
  logic              busy_o;

  trigger_window_gen #(
    .GPIO_W(GPIO_W), .TRIGGERBIT(TRIGGERBIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
    .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o),
    .gpio_o(gpio_o), .trigger_o(trigger_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  // Model: a window is described by the cycle the trigger goes high (m_on)
  // and the first cycle it is low again (m_off). An aborted delay is a window
  // with m_on == m_off.
  bit          m_have = 0;
  longint      m_on = 0, m_off = 0;
  longint      m_hold = 0;
  logic [31:0] m_delay = 0, m_len = 0;
  logic [7:0]  m_gpio = 0;

  int     hi_count = 0;
  longint rise_cyc = -1;
  logic   prev_trig = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_phase(input longint c);
    if (!m_have) return 0;
    if (c < m_on) return 1;
    if (c < m_off) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] m_cycles(input longint c);
    if (m_have && m_phase(c) == 3) return 32'(m_off - m_on);
    return 32'(m_hold);
  endfunction

  function automatic logic [31:0] m_bytes(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input longint c);
    int ph;
    ph = m_phase(c);
    case (a[4:2])
      3'd1:    return m_delay;
      3'd2:    return m_len;
      3'd3:    return {29'd0, (ph == 3), 2'(ph)};
      3'd4:    return m_cycles(c);
      3'd5:    return 32'(m_gpio);
      default: return 32'd0;
    endcase
  endfunction

  task automatic apply_write(input longint t, input int ph);
    logic [31:0] tmp;
    case (dev_addr_i[4:2])
      3'd0: if (dev_be_i[0]) begin
        if (ph == 0 || ph == 3) begin
          if (dev_wdata_i[1] || dev_wdata_i[0]) begin
            m_hold = longint'(m_cycles(t));
            m_have = 1;
            m_on   = dev_wdata_i[1] ? t + 1 + longint'(m_delay) : t + 1;
            m_off  = (m_len == 0) ? INF : m_on + longint'(m_len);
          end else if (dev_wdata_i[3] && ph == 3) begin
            m_hold = longint'(m_cycles(t));
            m_have = 0;
          end
        end else if (dev_wdata_i[2]) begin
          if (ph == 1) begin
            m_on  = t + 1;
            m_off = t + 1;
          end else if (t + 1 < m_off) begin
            m_off = t + 1;
          end
        end
      end
      3'd1: if (ph == 0 || ph == 3) m_delay = m_bytes(m_delay, dev_wdata_i, dev_be_i);
      3'd2: if (ph == 0 || ph == 3) m_len = m_bytes(m_len, dev_wdata_i, dev_be_i);
      3'd5: begin
        tmp    = m_bytes(32'(m_gpio), dev_wdata_i, dev_be_i);
        m_gpio = tmp[7:0];
      end
      default: ;
    endcase
  endtask

  // One clock: update the model from the inputs driven this cycle, then check
  // every output in the following cycle.
  task automatic tick();
    logic        nrv;
    logic [31:0] nrd;
    logic [7:0]  eg;
    int          ph;
    longint      t;
    t  = cyc;
    ph = m_phase(t);
    if (rst) begin
      nrv = 1'b0; nrd = '0;
      m_have = 0; m_hold = 0; m_delay = 0; m_len = 0; m_gpio = 0;
    end else begin
      nrv = dev_req_i;
      nrd = (dev_req_i && !dev_we_i) ? m_read(dev_addr_i, t) : 32'd0;
      if (dev_req_i && dev_we_i) apply_write(t, ph);
    end
    @(posedge clk);
    #1;
    cyc++;
    ph = m_phase(cyc);
    eg = m_gpio;
    eg[TRIGGERBIT] = (ph == 2);
    check_eq("rvalid", 32'(dev_rvalid_o), 32'(nrv));
    check_eq("rdata", dev_rdata_o, nrd);
    check_eq("trigger", 32'(trigger_o), 32'(ph == 2));
    check_eq("busy", 32'(busy_o), 32'(ph == 1 || ph == 2));
    check_eq("gpio", 32'(gpio_o), 32'(eg));
    if (trigger_o && !prev_trig) rise_cyc = cyc;
    if (trigger_o) hi_count++;
    prev_trig = trigger_o;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    dev_req_i = 1'b1; dev_we_i = 1'b1; dev_addr_i = a; dev_be_i = be; dev_wdata_i = d;
    tick();
    dev_req_i = 1'b0; dev_we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    dev_req_i = 1'b1; dev_we_i = 1'b0; dev_addr_i = a; dev_be_i = 4'hF; dev_wdata_i = '0;
    tick();
    d = dev_rdata_o;
    dev_req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] rd;
    longint      t;
    int          r;
    rst = 1'b1; dev_req_i = 1'b0; dev_we_i = 1'b0; dev_be_i = '0;
    dev_addr_i = '0; dev_wdata_i = '0;
    idle(2);
    rst = 1'b0;
    bus_read(5'h0C, rd);
    check_eq("reset_status", rd, 32'd0);
    check_eq("reset_gpio", 32'(gpio_o), 32'd0);

    // Bus and GPIO
    bus_write(5'h14, 4'h1, 32'hFF);
    check_eq("gpio_idle", 32'(gpio_o), 32'hFE);
    bus_read(5'h18, rd);
    check_eq("unmapped_read", rd, 32'd0);
    bus_write(5'h08, 4'h3, 32'h12345678);
    bus_read(5'h08, rd);
    check_eq("length_be", rd, 32'h5678);

    // Manual window
    bus_write(5'h08, 4'hF, 32'd0);
    hi_count = 0;
    t = cyc;
    bus_write(5'h00, 4'h1, 32'h1);
    check_eq("manual_rise", 32'(rise_cyc - t), 32'd1);
    idle(19);
    bus_write(5'h00, 4'h1, 32'h4);
    check_eq("manual_hi", 32'(hi_count), 32'd20);
    bus_read(5'h10, rd);
    check_eq("manual_cycles", rd, 32'd20);
    bus_read(5'h0C, rd);
    check_eq("manual_status", rd, 32'h7);

    // Auto window
    bus_write(5'h04, 4'hF, 32'd5);
    bus_write(5'h08, 4'hF, 32'd3);
    hi_count = 0;
    t = cyc;
    bus_write(5'h00, 4'h1, 32'h2);
    idle(12);
    check_eq("auto_rise", 32'(rise_cyc - t), 32'd6);
    check_eq("auto_hi", 32'(hi_count), 32'd3);
    bus_read(5'h10, rd);
    check_eq("auto_cycles", rd, 32'd3);

    // Zero delay and re-arm
    bus_write(5'h04, 4'hF, 32'd0);
    bus_write(5'h08, 4'hF, 32'd1);
    hi_count = 0;
    t = cyc;
    bus_write(5'h00, 4'h1, 32'h2);
    check_eq("zd_rise", 32'(rise_cyc - t), 32'd1);
    idle(3);
    bus_read(5'h0C, rd);
    check_eq("zd_status", rd, 32'h7);
    t = cyc;
    bus_write(5'h00, 4'h1, 32'h2);
    check_eq("rearm_rise", 32'(rise_cyc - t), 32'd1);
    bus_read(5'h0C, rd);
    check_eq("rearm_done_clr", rd, 32'h2);
    idle(2);
    check_eq("rearm_hi", 32'(hi_count), 32'd2);

    // Abort during delay
    bus_write(5'h00, 4'h1, 32'h8);
    bus_write(5'h04, 4'hF, 32'd100);
    bus_write(5'h08, 4'hF, 32'd4);
    hi_count = 0;
    t = cyc;
    bus_write(5'h00, 4'h1, 32'h2);
    idle(2);
    bus_write(5'h04, 4'hF, 32'd7);
    bus_read(5'h04, rd);
    check_eq("delay_locked", rd, 32'd100);
    idle(5);
    bus_write(5'h00, 4'h1, 32'h4);
    idle(5);
    check_eq("abort_hi", 32'(hi_count), 32'd0);
    bus_read(5'h0C, rd);
    check_eq("abort_status", rd, 32'h7);
    bus_read(5'h10, rd);
    check_eq("abort_cycles", rd, 32'd0);

    // Reset mid-window
    bus_write(5'h14, 4'h1, 32'hAA);
    bus_write(5'h08, 4'hF, 32'd0);
    bus_write(5'h00, 4'h1, 32'h1);
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_trigger", 32'(trigger_o), 32'd0);
    check_eq("rst_gpio", 32'(gpio_o), 32'd0);
    bus_read(5'h0C, rd);
    check_eq("rst_status", rd, 32'd0);
    bus_read(5'h10, rd);
    check_eq("rst_cycles", rd, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end else if (r < 28) begin
        tick();
      end else if (r < 32) begin
        bus_write(5'(24 + $urandom_range(0, 7)), 4'($urandom), $urandom);
      end else if (r < 50) begin
        bus_read(5'($urandom), rd);
      end else if (r < 66) begin
        bus_write(5'($urandom_range(0, 3)), 4'($urandom), 32'($urandom_range(0, 15)));
      end else if (r < 80) begin
        bus_write(5'(4 + $urandom_range(0, 3)), 4'($urandom), 32'($urandom_range(0, 15)));
      end else if (r < 92) begin
        bus_write(5'(8 + $urandom_range(0, 3)), 4'($urandom), 32'($urandom_range(0, 10)));
      end else begin
        bus_write(5'(20 + $urandom_range(0, 3)), 4'($urandom), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
